arbitro_mux_8: RTL and testbench
================================

Name: arbitro_mux_8

Overview:
- Round-robin arbiter and sequencer for the shared 8:1 one-bit multiplexer path of the ULA.
- Up to 8 requesters compete for the single mux output. The block drives the 3-bit select and a one-hot grant.
- Grants are fair and rotate. An optional hold limit preempts a requester that does not release.
- Sits between the requesting units and the mux select input; the mux itself is unchanged.

Parameters:
- MAX_POSSE, 16, maximum consecutive grant cycles before preemption when others are waiting; 0 disables preemption.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_POSSE.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request per requester; req[k] is held high until gnt[k] is seen and then for as long as the path is needed.
- gnt  output  8  one-hot grant, registered; all zero when no owner.
- sel  output  3  mux select, registered; equals the index of the asserted gnt bit; holds its last value when idle.
- valido  output  1  high exactly when gnt is nonzero.
- preempcao  output  1  one-cycle pulse in the cycle the block enters GUARDA because of a timeout.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0, sel=0, valido=0, preempcao=0.
  - State OCIOSO, hold counter 0, pointer ptr=7, so requester 0 has the highest priority first.
- Priority search: candidates are the requesters with req high. Search starts at ptr+1 and wraps modulo 8; the first candidate found wins. ptr is updated to the winner on every grant.
- OCIOSO:
  - If req==0, stay.
  - Otherwise, on the next edge: grant the winner (gnt one-hot, sel=index, valido=1), counter cleared to 1, go to CONCEDIDO.
  - Latency from req to gnt is 1 cycle.
- CONCEDIDO (owner k):
  - Release: req[k]=0 sampled.
    - If other requests are pending, the next winner is granted on the next edge with no idle gap.
    - Otherwise gnt=0, valido=0, go to OCIOSO.
  - Timeout: counter==MAX_POSSE, MAX_POSSE!=0, req[k] still high, and any other req high.
    - Go to GUARDA. gnt=0, valido=0, preempcao=1 for that cycle. k becomes lowest priority because ptr=k.
  - Timeout with no other requester: k keeps the grant and the counter reloads to 1. No pulse.
  - Otherwise the counter increments; it saturates and never wraps.
- GUARDA (exactly 1 cycle):
  - gnt=0, sel holds k.
  - Next edge: arbitrate as in OCIOSO. k may win only if it is the sole requester.
- Simultaneous events:
  - Release and timeout in the same cycle count as a release: no preempcao, no GUARDA.
  - New requests arriving during CONCEDIDO wait; they never preempt before timeout.
- Invariants:
  - gnt is never multi-hot.
  - sel changes only on a grant edge.
  - A requester with req low is never newly granted.
  - Any continuously requesting input is granted within 7 grant turns (fairness bound).
- Reset mid-grant: outputs clear immediately and asynchronously. Arbitration restarts from ptr=7 after rst_n rises; the first grant comes no earlier than 1 cycle after the first sampled edge.
- State encoding: 2-bit, OCIOSO=00, CONCEDIDO=01, GUARDA=10. 11 is illegal and recovers to OCIOSO with gnt cleared.

Decomposition:
- Shared package (ula_pkg) holds:
  - N_ENTRADAS=8 and SEL_W=3.
  - The state encoding constants.
  - The default MAX_POSSE.
- One sub-module, prioridade_rr_8: combinational round-robin search.
  - Inputs: req[7:0], ptr[2:0], mascara[7:0] (excludes the current owner on release or timeout).
  - Outputs: achou and idx[2:0].
- arbitro_mux_8 holds the FSM, the counter, ptr, and the output registers.

Test Plan:
- Reset, then req=8'b0000_0001 → next cycle gnt=01, sel=0, valido=1. Drop req → next cycle gnt=0, valido=0.
- Reset, then req=8'hFF held, each owner drops req for 1 cycle after 2 cycles of grant → grant order 0,1,2,…,7,0. Every cycle shows one-hot gnt and sel equal to its index.
- Owner 3 active, req[5] and req[1] rise → on release of 3, gnt moves directly to 5 with no gap, then 1 after 5 releases.
- MAX_POSSE=4, req[2] held, req[6] raised at cycle 1 → gnt[2] for 4 cycles, then 1 GUARDA cycle with preempcao=1 and gnt=0, then gnt[6], sel=6.
- MAX_POSSE=4, only req[4] held for 20 cycles → gnt[4] continuous, preempcao never asserted.
- rst_n pulled low while gnt=8'h20 → gnt, valido, and sel clear without a clock edge. After release with req=8'h22, first grant goes to 1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared constants and state encoding for the ULA mux-path arbiter.
package ula_pkg;

    localparam int N_ENTRADAS = 8;
    localparam int SEL_W      = 3;

    localparam int unsigned MAX_POSSE_PADRAO = 16;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        CONCEDIDO = 2'b01,
        GUARDA    = 2'b10
    } estado_t;

endpackage

// File: rtl/prioridade_rr_8.sv
// Combinational round-robin search: first unmasked requester after ptr, wrapping mod 8.
module prioridade_rr_8
    import ula_pkg::*;
(
    input  logic [N_ENTRADAS-1:0] req,
    input  logic [SEL_W-1:0]      ptr,
    input  logic [N_ENTRADAS-1:0] mascara,
    output logic                  achou,
    output logic [SEL_W-1:0]      idx
);

    logic [N_ENTRADAS-1:0] cand;
    logic [SEL_W-1:0]      pos;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        cand  = req & ~mascara;
        achou = 1'b0;
        idx   = '0;
        pos   = '0;
        // Offset 8 truncates to ptr itself, so the last requester searched is ptr.
        for (int i = 1; i <= N_ENTRADAS; i++) begin
            pos = ptr + SEL_W'(i);
            if (!achou && cand[pos]) begin
                achou = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/arbitro_mux_8.sv
// Round-robin arbiter driving select and one-hot grant of the shared 8:1 one-bit mux path.
module arbitro_mux_8
    import ula_pkg::*;
#(
    parameter int unsigned MAX_POSSE = MAX_POSSE_PADRAO,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_ENTRADAS-1:0] req,
    output logic [N_ENTRADAS-1:0] gnt,
    output logic [SEL_W-1:0]      sel,
    output logic                  valido,
    output logic                  preempcao
);

    estado_t               estado_q, estado_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;
    logic [N_ENTRADAS-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  preempcao_q, preempcao_d;

    logic [N_ENTRADAS-1:0] mascara;
    logic                  achou;
    logic [SEL_W-1:0]      idx;
    logic                  dono_req;
    logic                  outros;
    logic                  limite;
    logic                  conceder;

    // gnt_q is the one-hot owner, so it doubles as the owner mask.
    assign dono_req = |(req & gnt_q);
    assign outros   = |(req & ~gnt_q);
    assign limite   = (MAX_POSSE != 0) && (cnt_q == CNT_W'(MAX_POSSE));
    assign mascara  = (estado_q == CONCEDIDO) ? gnt_q : '0;

    prioridade_rr_8 u_prioridade (
        .req     (req),
        .ptr     (ptr_q),
        .mascara (mascara),
        .achou   (achou),
        .idx     (idx)
    );

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        preempcao_d = 1'b0;
        conceder    = 1'b0;

        case (estado_q)
            OCIOSO, GUARDA: begin
                gnt_d    = '0;
                estado_d = OCIOSO;
                conceder = achou;
            end
            CONCEDIDO: begin
                if (!dono_req) begin
                    // Release wins over a coinciding timeout.
                    if (achou) begin
                        conceder = 1'b1;
                    end else begin
                        gnt_d    = '0;
                        estado_d = OCIOSO;
                    end
                end else if (limite && outros) begin
                    gnt_d       = '0;
                    estado_d    = GUARDA;
                    preempcao_d = 1'b1;
                end else if (limite) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d    = '0;
                estado_d = OCIOSO;
            end
        endcase

        if (conceder) begin
            estado_d = CONCEDIDO;
            gnt_d    = N_ENTRADAS'(1) << idx;
            sel_d    = idx;
            ptr_d    = idx;
            cnt_d    = CNT_W'(1);
        end
    end

    // NOTE: non-blocking updates so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            cnt_q       <= '0;
            ptr_q       <= SEL_W'(N_ENTRADAS - 1);
            gnt_q       <= '0;
            sel_q       <= '0;
            preempcao_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            preempcao_q <= preempcao_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign valido    = |gnt_q;
    assign preempcao = preempcao_q;

endmodule

// File: tb/tb_arbitro_mux_8.sv
// Self-checking bench for arbitro_mux_8: directed scenarios plus randomized traffic vs a behavioural model.
module tb_arbitro_mux_8;

    localparam int MAXP = 4;
    localparam int CNT_MAX = 31;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valido;
    logic       preempcao;

    int n_checks;
    int n_errors;

    // Behavioural model: owner index (-1 = nobody), priority pointer, hold count.
    int  m_owner;
    int  m_ptr;
    int  m_cnt;
    int  m_sel;
    bit  m_pre;
    bit  m_new_grant;

    int  wait_turns [8];
    int  max_wait;

    arbitro_mux_8 #(.MAX_POSSE(MAXP), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .valido    (valido),
        .preempcao (preempcao)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        int j;
        for (int off = 1; off <= 8; off++) begin
            j = (p + off) % 8;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 7;
        m_cnt   = 0;
        m_sel   = 0;
        m_pre   = 1'b0;
        m_new_grant = 1'b0;
        for (int j = 0; j < 8; j++) wait_turns[j] = 0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = w;
        m_sel   = w;
        m_cnt   = 1;
        m_new_grant = 1'b1;
    endtask

    task automatic model_step(input logic [7:0] r);
        int  w;
        int  k;
        bit  others;
        m_pre = 1'b0;
        m_new_grant = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            k = m_owner;
            others = 1'b0;
            for (int j = 0; j < 8; j++) if (j != k && r[j]) others = 1'b1;
            if (!r[k]) begin
                w = pick(r, m_ptr);
                if (w >= 0) model_grant(w);
                else m_owner = -1;
            end else if (m_cnt == MAXP && others) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_cnt == MAXP) begin
                m_cnt = 1;
            end else if (m_cnt < CNT_MAX) begin
                m_cnt = m_cnt + 1;
            end
        end
        // Fairness bookkeeping: grant turns seen by each still-waiting requester.
        for (int j = 0; j < 8; j++) begin
            if (!r[j] || j == m_owner) wait_turns[j] = 0;
            else if (m_new_grant) wait_turns[j]++;
            if (wait_turns[j] > max_wait) max_wait = wait_turns[j];
        end
    endtask

    function automatic logic [7:0] exp_gnt();
        return (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_gnt"},    32'(gnt),       32'(exp_gnt()));
        check({tag, "_sel"},    32'(sel),       32'(m_sel));
        check({tag, "_valido"}, 32'(valido),    32'(m_owner >= 0));
        check({tag, "_pre"},    32'(preempcao), 32'(m_pre));
        check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'(1));
    endtask

    task automatic cycle(input logic [7:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare_all("rst");
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] prev_gnt;
        int         order [$];
        int         exp_seq [6];
        logic [7:0] rnd_req;

        n_checks = 0;
        n_errors = 0;
        max_wait = 0;
        rst_n    = 1'b0;
        req      = 8'h00;
        model_reset();

        // Single requester: 1-cycle latency, then release to idle.
        do_reset();
        cycle(8'h01, "t1_grant");
        check("t1_gnt", 32'(gnt), 32'h01);
        check("t1_valido", 32'(valido), 32'd1);
        cycle(8'h00, "t1_release");
        check("t1_idle", 32'(gnt), 32'h00);

        // All requesting, each owner releases after 2 grant cycles: order 0..7,0.
        do_reset();
        prev_gnt = 8'h00;
        for (int c = 0; c < 60 && order.size() < 9; c++) begin
            r = 8'hFF;
            if (m_owner >= 0 && m_cnt == 2) r[m_owner] = 1'b0;
            cycle(r, "t2");
            if (valido && gnt != prev_gnt) order.push_back(int'(sel));
            prev_gnt = gnt;
        end
        check("t2_len", 32'(order.size()), 32'd9);
        for (int i = 0; i < order.size(); i++) check("t2_order", 32'(order[i]), 32'(i % 8));

        // Owner 3, then 5 and 1 queue up: handover 3->5->1 with no idle gap.
        do_reset();
        cycle(8'h08, "t3");
        check("t3_own3", 32'(gnt), 32'h08);
        cycle(8'h2A, "t3");
        cycle(8'h22, "t3");
        check("t3_own5", 32'(gnt), 32'h20);
        check("t3_sel5", 32'(sel), 32'd5);
        cycle(8'h02, "t3");
        check("t3_own1", 32'(gnt), 32'h02);
        cycle(8'h00, "t3");

        // Timeout: 2 holds 4 cycles, one GUARDA cycle with pulse, then 6.
        do_reset();
        exp_seq = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h40};
        cycle(8'h04, "t4");
        check("t4_seq", 32'(gnt), 32'(exp_seq[0]));
        for (int i = 1; i < 6; i++) begin
            cycle(8'h44, "t4");
            check("t4_seq", 32'(gnt), 32'(exp_seq[i]));
            check("t4_pulse", 32'(preempcao), 32'(i == 4));
        end
        check("t4_sel6", 32'(sel), 32'd6);
        cycle(8'h00, "t4");

        // Sole requester past the limit keeps the grant with no pulse.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(8'h10, "t5");
            check("t5_gnt", 32'(gnt), 32'h10);
            check("t5_nopre", 32'(preempcao), 32'd0);
        end
        cycle(8'h00, "t5");

        // Asynchronous reset mid-grant, then restart from ptr=7.
        do_reset();
        cycle(8'h20, "t6");
        check("t6_own5", 32'(gnt), 32'h20);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_gnt", 32'(gnt), 32'h00);
        check("t6_async_valido", 32'(valido), 32'd0);
        check("t6_async_sel", 32'(sel), 32'd0);
        req = 8'h22;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(8'h22, "t6");
        check("t6_first", 32'(gnt), 32'h02);
        cycle(8'h00, "t6");
        cycle(8'h00, "t6");

        // Randomized traffic: waiting requesters hold req, owners drop at random.
        do_reset();
        max_wait = 0;
        rnd_req  = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            for (int j = 0; j < 8; j++) begin
                if (rnd_req[j]) begin
                    if (m_owner == j && $urandom_range(5) == 0) rnd_req[j] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rnd_req[j] = 1'b1;
                end
            end
            cycle(rnd_req, "rnd");
        end
        check("fairness", 32'(max_wait <= 7), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
